// File: rtl/mul_arb_pkg.sv
// Shared constants and state encoding for the multiplier arbiter.
// Imported by rr_pick and mul_arbiter.
package mul_arb_pkg;

    localparam int SIZE_DEF = 32;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after
// (last owner + 1) mod NREQ wins.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_win,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        w_j   = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = IW'((int'(i_last) + k) % NREQ);
            if (i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
        o_win = '0;
        if (o_any) o_win[o_idx] = 1'b1;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one shift-add multiplier among NREQ requesters.
// Define MUL_ARB_TIMEOUT_EN to add the BUSY/ACK watchdog.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = 2 * SIZE + 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SIZE-1:0]   a_in,
    input  logic [NREQ*SIZE-1:0]   b_in,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [2*SIZE-1:0]      rsp_prod,
    output logic                   rsp_err,
    input  logic [NREQ-1:0]        rsp_ack,
    output logic [SIZE-1:0]        mul_a,
    output logic [SIZE-1:0]        mul_b,
    output logic                   mul_valid_data,
    output logic                   mul_ack,
    input  logic                   mul_done,
    input  logic                   mul_ret_ack,
    input  logic [2*SIZE-1:0]      mul_prod
);

    localparam int IW = idx_w(NREQ);

    state_t              r_state;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_last;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [2*SIZE-1:0]   r_prod;
    logic [SIZE-1:0]     r_mul_a;
    logic [SIZE-1:0]     r_mul_b;
    logic                r_valid;
    logic                r_ack;

    logic [NREQ-1:0]     w_win;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic [NREQ-1:0]     w_owner_oh;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]       r_cnt;
    logic                r_err;
    logic                w_tmo;
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_win),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    always_comb begin
        w_owner_oh = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_last      <= IW'(NREQ - 1);
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_prod      <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_valid     <= 1'b0;
            r_ack       <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_grant <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            // Counts only while waiting on the multiplier.
            r_cnt <= (r_state == ST_BUSY || r_state == ST_ACK)
                   ? r_cnt + 1'b1 : '0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_mul_a <= a_in[w_idx*SIZE +: SIZE];
                        r_mul_b <= b_in[w_idx*SIZE +: SIZE];
                        r_owner <= w_idx;
                        r_grant <= w_win;
                        r_valid <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        r_prod  <= mul_prod;
                        r_valid <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
`ifdef MUL_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_valid     <= 1'b0;
                        r_ack       <= 1'b0;
                        r_prod      <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= ST_RESP;
`endif
                    end
                end
                ST_ACK: begin
                    if (mul_ret_ack) begin
                        r_ack       <= 1'b0;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= ST_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_valid     <= 1'b0;
                        r_ack       <= 1'b0;
                        r_prod      <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ack[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_last      <= r_owner;
                        r_state     <= ST_IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant          = r_grant;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_prod       = r_prod;
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;
    assign mul_valid_data = r_valid;
    assign mul_ack        = r_ack;

`ifdef MUL_ARB_TIMEOUT_EN
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a handshaking multiplier model
// and a round-robin reference model.
module tb_mul_arbiter;

    localparam int SIZE    = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 72;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] a_in;
    logic [NREQ*SIZE-1:0] b_in;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      rsp_valid;
    logic [2*SIZE-1:0]    rsp_prod;
    logic                 rsp_err;
    logic [NREQ-1:0]      rsp_ack;
    logic [SIZE-1:0]      mul_a;
    logic [SIZE-1:0]      mul_b;
    logic                 mul_valid_data;
    logic                 mul_ack;
    logic                 mul_done;
    logic                 mul_ret_ack;
    logic [2*SIZE-1:0]    mul_prod;

    int total = 0;
    int bad = 0;
    int model_last;
    int lat = 34;
    bit hang = 1'b0;
    int last_idx;
    logic [63:0] last_prod;

    always #5 clk = ~clk;

    mul_arbiter #(
        .SIZE    (SIZE),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .a_in           (a_in),
        .b_in           (b_in),
        .grant          (grant),
        .rsp_valid      (rsp_valid),
        .rsp_prod       (rsp_prod),
        .rsp_err        (rsp_err),
        .rsp_ack        (rsp_ack),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_valid_data (mul_valid_data),
        .mul_ack        (mul_ack),
        .mul_done       (mul_done),
        .mul_ret_ack    (mul_ret_ack),
        .mul_prod       (mul_prod)
    );

    // Multiplier model: latency, then done/ack/ret_ack handshake.
    int m_st;
    int m_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st        <= 0;
            m_cnt       <= 0;
            mul_done    <= 1'b0;
            mul_ret_ack <= 1'b0;
            mul_prod    <= '0;
        end else begin
            case (m_st)
                0: if (mul_valid_data) begin
                    m_cnt    <= lat;
                    mul_prod <= 64'(mul_a) * 64'(mul_b);
                    m_st     <= 1;
                end
                1: if (!hang) begin
                    if (m_cnt == 0) begin
                        mul_done <= 1'b1;
                        m_st     <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                2: if (mul_ack) begin
                    mul_done    <= 1'b0;
                    mul_ret_ack <= 1'b1;
                    m_st        <= 3;
                end
                3: if (!mul_ack) begin
                    mul_ret_ack <= 1'b0;
                    m_st        <= 0;
                end
                default: m_st <= 0;
            endcase
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last = NREQ - 1;
    endtask

    // One full transaction; expected owner from the round-robin rule.
    task automatic run_txn(input bit drop);
        int e;
        bit ok;
        bit ack_seen;
        logic [63:0] ep;
        e = -1;
        for (int k = 1; k <= NREQ; k++)
            if (e < 0 && req[(model_last + k) % NREQ])
                e = (model_last + k) % NREQ;
        if (e < 0) e = 0;
        ep = 64'(a_in[e*SIZE +: SIZE]) * 64'(b_in[e*SIZE +: SIZE]);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (grant != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_timely", 64'(ok), 64'd1);
        check("grant", 64'(grant), 64'(1 << e));
        check("valid_data", 64'(mul_valid_data), 64'd1);
        check("mul_a", 64'(mul_a), 64'(a_in[e*SIZE +: SIZE]));
        check("mul_b", 64'(mul_b), 64'(b_in[e*SIZE +: SIZE]));
        if (drop) req[e] = 1'b0;
        @(negedge clk);
        check("grant_pulse", 64'(grant), 64'd0);
        ok = 1'b0;
        ack_seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (mul_ack) ack_seen = 1'b1;
            if (rsp_valid != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_timely", 64'(ok), 64'd1);
        check("mul_ack_seen", 64'(ack_seen), 64'd1);
        check("rsp_valid", 64'(rsp_valid), 64'(1 << e));
        check("rsp_prod", rsp_prod, ep);
        check("rsp_err", 64'(rsp_err), 64'd0);
        last_idx = e;
        last_prod = rsp_prod;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rsp_ack = NREQ'(1 << ((e + 1) % NREQ));
        @(negedge clk);
        check("nonowner_ack", 64'(rsp_valid), 64'(1 << e));
        rsp_ack = NREQ'(1 << e);
        @(negedge clk);
        rsp_ack = '0;
        check("rsp_clear", 64'(rsp_valid), 64'd0);
        check("no_early_grant", 64'(grant), 64'd0);
        model_last = e;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        reset = 1'b1;
        req = '0;
        rsp_ack = '0;
        a_in = '0;
        b_in = '0;
        model_last = NREQ - 1;
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_valid_data", 64'(mul_valid_data), 64'd0);
        check("rst_mul_ack", 64'(mul_ack), 64'd0);
        check("rst_prod", rsp_prod, 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request
        lat = 34;
        a_in[2*SIZE +: SIZE] = 32'd7;
        b_in[2*SIZE +: SIZE] = 32'd9;
        req = 4'b0100;
        run_txn(1'b1);
        check("single_idx", 64'(last_idx), 64'd2);
        check("single_prod", last_prod, 64'd63);

        // All four from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*SIZE +: SIZE] = 32'(i + 1);
            b_in[i*SIZE +: SIZE] = 32'd3;
        end
        lat = 5;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            run_txn(1'b1);
            check("all4_idx", 64'(last_idx), 64'(i));
            check("all4_prod", last_prod, 64'(3 * (i + 1)));
        end

        // Fairness: req[1] held, req[3] pending
        a_in = {$urandom, $urandom, $urandom, $urandom};
        b_in = {$urandom, $urandom, $urandom, $urandom};
        req = 4'b1010;
        run_txn(1'b0);
        check("fair_1", 64'(last_idx), 64'd1);
        run_txn(1'b1);
        check("fair_2", 64'(last_idx), 64'd3);
        run_txn(1'b1);
        check("fair_3", 64'(last_idx), 64'd1);

        // Full width
        a_in[0 +: SIZE] = 32'hFFFF_FFFF;
        b_in[0 +: SIZE] = 32'hFFFF_FFFF;
        req = 4'b0001;
        run_txn(1'b1);
        check("full_width", last_prod, 64'hFFFF_FFFE_0000_0001);

        // Randomized traffic
        for (int it = 0; it < 10; it++) begin
            req = req | NREQ'($urandom_range(1, 15));
            a_in = {$urandom, $urandom, $urandom, $urandom};
            b_in = {$urandom, $urandom, $urandom, $urandom};
            lat = $urandom_range(0, 40);
            run_txn(1'($urandom_range(0, 1)));
        end
        for (int it = 0; it < NREQ && req != 0; it++) run_txn(1'b1);

        // Reset during BUSY
        lat = 30;
        req = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_grant", 64'(ok), 64'd1);
        req = '0;
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(mul_valid_data), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        check("mid_rst_valid", 64'(mul_valid_data), 64'd0);
        req = 4'b0101;
        @(negedge clk);
        reset = 1'b0;
        model_last = NREQ - 1;
        lat = 3;
        run_txn(1'b1);
        check("post_rst_idx", 64'(last_idx), 64'd0);
        run_txn(1'b1);
        check("post_rst_idx2", 64'(last_idx), 64'd2);

        // Multiplier never finishes
        hang = 1'b1;
        req = 4'b1000;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("hang_grant", 64'(ok), 64'd1);
        req = '0;
`ifdef MUL_ARB_TIMEOUT_EN
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_seen", 64'(ok), 64'd1);
        check("tmo_cycles",
              64'(n >= TIMEOUT - 1 && n <= TIMEOUT + 1), 64'd1);
        check("tmo_valid", 64'(rsp_valid), 64'b1000);
        check("tmo_err", 64'(rsp_err), 64'd1);
        check("tmo_prod", rsp_prod, 64'd0);
        check("tmo_vd", 64'(mul_valid_data), 64'd0);
        check("tmo_ack", 64'(mul_ack), 64'd0);
        rsp_ack = 4'b1000;
        @(negedge clk);
        rsp_ack = '0;
        check("tmo_clear", 64'(rsp_valid), 64'd0);
`else
        n = 0;
        repeat (200) @(negedge clk);
        check("hang_no_rsp", 64'(rsp_valid), 64'd0);
        check("hang_busy", 64'(mul_valid_data), 64'd1);
        check("hang_err", 64'(rsp_err), 64'd0);
`endif
        hang = 1'b0;
        do_reset();
        check("end_idle", 64'(mul_valid_data), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
